// File: rtl/mci_pkg.sv
// Shared MCI types: boot sequencer state encoding and MCU reset-request arbiter states.
package mci_pkg;

  typedef enum logic [3:0] {
    BOOT_IDLE             = 4'd0,
    BOOT_OTP_FC           = 4'd1,
    BOOT_MCU              = 4'd2,
    BOOT_WAIT_CPTRA_GO    = 4'd3,
    BOOT_CPTRA            = 4'd4,
    BOOT_WAIT_MCU_RST_REQ = 4'd5,
    BOOT_RST_MCU          = 4'd6,
    BOOT_UNKNOWN          = 4'd15
  } mci_boot_fsm_state_e;

  typedef enum logic [1:0] {
    ARB_IDLE     = 2'd0,
    ARB_REQ      = 2'd1,
    ARB_WAIT_RST = 2'd2,
    ARB_DONE     = 2'd3
  } mci_rst_arb_state_e;

endpackage

// File: rtl/mci_rr_arb.sv
// Combinational round-robin picker: first eligible index at or after ptr, wrapping.
module mci_rr_arb #(
  parameter int N = 3,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    eligible,
  input  logic [ID_W-1:0] ptr,
  output logic [ID_W-1:0] winner,
  output logic            valid
);

  logic [2*N-1:0] rotated;
  logic           found;
  int             cand;

  // Rotating a doubled copy puts the ptr position at bit 0, so the lowest set bit wins.
  always_comb begin
    rotated = {eligible, eligible} >> ptr;
    winner  = '0;
    found   = 1'b0;
    cand    = 0;
    for (int j = 0; j < N; j++) begin
      if (!found && rotated[j]) begin
        found = 1'b1;
        cand  = int'(ptr) + j;
        if (cand >= N) cand = cand - N;
        winner = ID_W'(cand);
      end
    end
    valid = |eligible;
  end

endmodule

// File: rtl/mci_mcu_rst_req_arb.sv
// Round-robin sharing of the MCU reset request among NUM_REQ requesters, with
// boot-sequencer handshake tracking, reset-type capture and completion timeout.
module mci_mcu_rst_req_arb
  import mci_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int TIMEOUT_WIDTH = 16,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     mci_rst_b,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_mask,
  input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
  input  mci_boot_fsm_state_e      boot_fsm,
  input  logic                     fw_hitless_upd_reset,
  output logic                     mcu_rst_req,
  output logic [NUM_REQ-1:0]       ack,
  output logic                     ack_hitless,
  output logic [NUM_REQ-1:0]       err,
  output logic                     busy,
  output logic [ID_W-1:0]          grant_id
);

  mci_rst_arb_state_e       state_q, state_d;
  logic [ID_W-1:0]          ptr_q, ptr_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [ID_W-1:0]          grant_id_q, grant_id_d;
  logic                     busy_q, busy_d;
  logic                     mcu_rst_req_q, mcu_rst_req_d;
  logic [NUM_REQ-1:0]       ack_q, ack_d;
  logic                     ack_hitless_q, ack_hitless_d;
  logic [NUM_REQ-1:0]       err_q, err_d;

  logic [NUM_REQ-1:0]       eligible;
  logic [ID_W-1:0]          winner;
  logic                     win_valid;
  logic [NUM_REQ-1:0]       grant_onehot;
  logic [ID_W-1:0]          next_ptr;
  logic [TIMEOUT_WIDTH-1:0] cnt_inc;
  logic                     timeout_hit;

  assign eligible = req & ~req_mask;

  mci_rr_arb #(.N(NUM_REQ)) u_rr_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .winner   (winner),
    .valid    (win_valid)
  );

  always_comb begin
    grant_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      grant_onehot[i] = (grant_id_q == ID_W'(i));
    end
  end

  assign next_ptr    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_id_q + ID_W'(1);
  assign cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + TIMEOUT_WIDTH'(1);
  assign timeout_hit = (timeout_cycles != '0) &&
                       (cnt_q == timeout_cycles - TIMEOUT_WIDTH'(1));

  // Timeout wins over handshake progress so a late sequencer response never yields both err and ack.
  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    grant_id_d    = grant_id_q;
    busy_d        = busy_q;
    mcu_rst_req_d = 1'b0;
    ack_d         = '0;
    err_d         = '0;
    ack_hitless_d = ack_hitless_q;

    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          grant_id_d = winner;
          busy_d     = 1'b1;
          cnt_d      = '0;
          state_d    = ARB_REQ;
        end
      end
      ARB_REQ, ARB_WAIT_RST: begin
        cnt_d = cnt_inc;
        if (timeout_hit) begin
          err_d   = grant_onehot;
          busy_d  = 1'b0;
          ptr_d   = next_ptr;
          state_d = ARB_IDLE;
        end else if (state_q == ARB_REQ) begin
          if (boot_fsm == BOOT_RST_MCU) begin
            ack_hitless_d = fw_hitless_upd_reset;
            state_d       = ARB_WAIT_RST;
          end else begin
            mcu_rst_req_d = (boot_fsm == BOOT_WAIT_MCU_RST_REQ);
          end
        end else if (boot_fsm == BOOT_WAIT_MCU_RST_REQ) begin
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        ack_d   = grant_onehot;
        busy_d  = 1'b0;
        ptr_d   = next_ptr;
        state_d = ARB_IDLE;
      end
      default: begin
        state_d       = ARB_IDLE;
        busy_d        = 1'b0;
        grant_id_d    = '0;
        ack_hitless_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!mci_rst_b) begin
      state_q       <= ARB_IDLE;
      ptr_q         <= '0;
      cnt_q         <= '0;
      grant_id_q    <= '0;
      busy_q        <= 1'b0;
      mcu_rst_req_q <= 1'b0;
      ack_q         <= '0;
      ack_hitless_q <= 1'b0;
      err_q         <= '0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      cnt_q         <= cnt_d;
      grant_id_q    <= grant_id_d;
      busy_q        <= busy_d;
      mcu_rst_req_q <= mcu_rst_req_d;
      ack_q         <= ack_d;
      ack_hitless_q <= ack_hitless_d;
      err_q         <= err_d;
    end
  end

  assign mcu_rst_req = mcu_rst_req_q;
  assign ack         = ack_q;
  assign ack_hitless = ack_hitless_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_mci_mcu_rst_req_arb.sv
// Bench for the MCU reset-request arbiter: cycle model plus directed scenarios.
module tb_mci_mcu_rst_req_arb;
  import mci_pkg::*;

  localparam int N  = 3;
  localparam int TW = 16;

  logic                clk = 1'b0;
  logic                mci_rst_b = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0]        req_mask = '0;
  logic [TW-1:0]       timeout_cycles = '0;
  mci_boot_fsm_state_e boot_fsm = BOOT_WAIT_MCU_RST_REQ;
  logic                fw_hitless_upd_reset = 1'b0;
  logic                mcu_rst_req;
  logic [N-1:0]        ack;
  logic                ack_hitless;
  logic [N-1:0]        err;
  logic                busy;
  logic [1:0]          grant_id;

  mci_mcu_rst_req_arb #(.NUM_REQ(N), .TIMEOUT_WIDTH(TW)) dut (
    .clk                  (clk),
    .mci_rst_b            (mci_rst_b),
    .req                  (req),
    .req_mask             (req_mask),
    .timeout_cycles       (timeout_cycles),
    .boot_fsm             (boot_fsm),
    .fw_hitless_upd_reset (fw_hitless_upd_reset),
    .mcu_rst_req          (mcu_rst_req),
    .ack                  (ack),
    .ack_hitless          (ack_hitless),
    .err                  (err),
    .busy                 (busy),
    .grant_id             (grant_id)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit compareEn = 1'b0;

  // Model: what a requester sees, tracked as "phase of the current grant" plus elapsed cycles.
  localparam int PH_FREE = 0, PH_ASKING = 1, PH_IN_RESET = 2, PH_COMPLETE = 3;
  int mPhase = PH_FREE, mGrant = 0, mNext = 0, mElapsed = 0;
  int mMcu = 0, mAck = 0, mErr = 0, mBusy = 0, mHit = 0;

  int grantLog[$];
  int lowRuns[$];
  int ackLog[$];
  int lowRun = 0;
  int mcuSeen = 0;
  bit busyPrev = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] m);
    req      = r;
    req_mask = m;
  endtask

  task automatic modelStep();
    int elig;
    int idx;
    mAck = 0;
    mErr = 0;
    if (mci_rst_b == 1'b0) begin
      mPhase = PH_FREE; mGrant = 0; mNext = 0; mElapsed = 0;
      mMcu = 0; mBusy = 0; mHit = 0;
      return;
    end
    if (mPhase == PH_FREE) begin
      mMcu = 0;
      elig = int'({29'b0, req & ~req_mask});
      for (int k = 0; k < N; k++) begin
        idx = (mNext + k) % N;
        if (mPhase == PH_FREE && ((elig >> idx) & 1) == 1) begin
          mGrant = idx; mBusy = 1; mElapsed = 0; mPhase = PH_ASKING;
        end
      end
    end else if (mPhase == PH_COMPLETE) begin
      mAck = 1 << mGrant; mBusy = 0; mMcu = 0;
      mNext = (mGrant + 1) % N; mPhase = PH_FREE;
    end else begin
      mElapsed++;
      if (timeout_cycles != 0 && mElapsed == int'(timeout_cycles)) begin
        mErr = 1 << mGrant; mBusy = 0; mMcu = 0;
        mNext = (mGrant + 1) % N; mPhase = PH_FREE;
      end else if (mPhase == PH_ASKING) begin
        if (boot_fsm == BOOT_RST_MCU) begin
          mMcu = 0; mHit = int'(fw_hitless_upd_reset); mPhase = PH_IN_RESET;
        end else begin
          mMcu = (boot_fsm == BOOT_WAIT_MCU_RST_REQ) ? 1 : 0;
        end
      end else begin
        mMcu = 0;
        if (boot_fsm == BOOT_WAIT_MCU_RST_REQ) mPhase = PH_COMPLETE;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    modelStep();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (compareEn) begin
      checkOutput("cyc_mcu_rst_req", 32'(mcu_rst_req), mMcu);
      checkOutput("cyc_ack", 32'(ack), mAck);
      checkOutput("cyc_err", 32'(err), mErr);
      checkOutput("cyc_busy", 32'(busy), mBusy);
      checkOutput("cyc_grant_id", 32'(grant_id), mGrant);
      checkOutput("cyc_ack_hitless", 32'(ack_hitless), mHit);
    end
  end

  initial forever begin
    @(negedge clk);
    if (compareEn) begin
      if (busy && !busyPrev) begin
        if (grantLog.size() > 0) lowRuns.push_back(lowRun);
        grantLog.push_back(int'(grant_id));
        lowRun = 0;
      end else if (!busy) begin
        lowRun++;
      end
      if (ack != '0) ackLog.push_back(int'(ack));
      if (mcu_rst_req) mcuSeen++;
      busyPrev = busy;
    end
  end

  task automatic clearLogs();
    grantLog.delete();
    lowRuns.delete();
    ackLog.delete();
    lowRun  = 0;
    mcuSeen = 0;
  endtask

  task automatic doReset();
    mci_rst_b = 1'b0;
    boot_fsm  = BOOT_WAIT_MCU_RST_REQ;
    fw_hitless_upd_reset = 1'b0;
    applyStimulus('0, '0);
    repeat (2) @(negedge clk);
    compareEn = 1'b1;
    mci_rst_b = 1'b1;
  endtask

  task automatic runSeqr(input int enterDly, input int retDly);
    int n = 0;
    while (mcu_rst_req !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("seqr_saw_mcu_rst_req", 32'(mcu_rst_req), 1);
    repeat (enterDly) @(negedge clk);
    boot_fsm = BOOT_RST_MCU;
    repeat (retDly) @(negedge clk);
    boot_fsm = BOOT_WAIT_MCU_RST_REQ;
  endtask

  task automatic waitAck(input logic [N-1:0] expected, input string name, output int n);
    n = 0;
    while (ack == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(ack), 32'(expected));
  endtask

  task automatic waitBusy(input string name);
    int n = 0;
    while (busy !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(busy), 1);
  endtask

  initial begin
    int n;
    int expGrant[4] = '{0, 1, 2, 0};
    int expAck[4]   = '{1, 2, 4, 1};

    @(negedge clk);
    doReset();
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_mcu_rst_req", 32'(mcu_rst_req), 0);
    checkOutput("rst_ack_err", 32'({ack, err}), 0);
    checkOutput("rst_grant_id", 32'(grant_id), 0);

    // Single requester, first-boot reset.
    clearLogs();
    applyStimulus(3'b001, 3'b000);
    runSeqr(3, 10);
    waitAck(3'b001, "t1_ack", n);
    checkOutput("t1_return_to_ack_cycles", n, 2);
    checkOutput("t1_ack_hitless", 32'(ack_hitless), 0);
    applyStimulus(3'b000, 3'b000);
    repeat (3) @(negedge clk);
    checkOutput("t1_ack_count", ackLog.size(), 1);

    // Masked requester is never served.
    clearLogs();
    applyStimulus(3'b010, 3'b010);
    repeat (100) @(negedge clk);
    checkOutput("mask_mcu_rst_req_cycles", mcuSeen, 0);
    checkOutput("mask_grants", grantLog.size(), 0);
    applyStimulus(3'b000, 3'b000);

    // All three held: round-robin from a fresh pointer.
    doReset();
    clearLogs();
    applyStimulus(3'b111, 3'b000);
    for (int i = 0; i < 4; i++) runSeqr(2, 4);
    waitAck(3'b001, "rr_last_ack", n);
    applyStimulus(3'b000, 3'b000);
    repeat (3) @(negedge clk);
    checkOutput("rr_grant_count", grantLog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr_grant_%0d", i), (i < grantLog.size()) ? grantLog[i] : -1, expGrant[i]);
      checkOutput($sformatf("rr_ack_%0d", i), (i < ackLog.size()) ? ackLog[i] : -1, expAck[i]);
    end
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("rr_busy_gap_%0d", i), (i < lowRuns.size()) ? lowRuns[i] : -1, 1);
    end

    // Timeout: pointer is at 1, sequencer never enters reset.
    clearLogs();
    timeout_cycles = 16'd20;
    applyStimulus(3'b011, 3'b000);
    waitBusy("to_busy");
    checkOutput("to_grant_id", 32'(grant_id), 1);
    n = 0;
    while (err == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("to_err_vec", 32'(err), 32'h2);
    checkOutput("to_err_cycles", n, 20);
    checkOutput("to_mcu_rst_req_dropped", 32'(mcu_rst_req), 0);
    checkOutput("to_no_ack", ackLog.size(), 0);
    applyStimulus(3'b001, 3'b000);
    runSeqr(2, 3);
    waitAck(3'b001, "to_next_ack", n);
    applyStimulus(3'b000, 3'b000);
    timeout_cycles = '0;

    // Hitless reset; requester drops its request right after the grant.
    clearLogs();
    fw_hitless_upd_reset = 1'b1;
    applyStimulus(3'b010, 3'b000);
    waitBusy("hl_busy");
    applyStimulus(3'b000, 3'b000);
    runSeqr(2, 5);
    waitAck(3'b010, "hl_ack", n);
    checkOutput("hl_ack_hitless", 32'(ack_hitless), 1);
    fw_hitless_upd_reset = 1'b0;

    // Reset while waiting for the MCU reset to complete.
    clearLogs();
    applyStimulus(3'b001, 3'b000);
    n = 0;
    while (mcu_rst_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("mr_grant_id", 32'(grant_id), 0);
    boot_fsm = BOOT_RST_MCU;
    repeat (4) @(negedge clk);
    checkOutput("mr_busy_before", 32'(busy), 1);
    mci_rst_b = 1'b0;
    @(negedge clk);
    checkOutput("mr_outputs_cleared", 32'({mcu_rst_req, ack, ack_hitless, err, busy, grant_id}), 0);
    boot_fsm = BOOT_WAIT_MCU_RST_REQ;
    applyStimulus(3'b000, 3'b000);
    @(negedge clk);
    mci_rst_b = 1'b1;
    applyStimulus(3'b101, 3'b000);
    waitBusy("mr_regrant_busy");
    checkOutput("mr_ptr_cleared_grant", 32'(grant_id), 0);
    runSeqr(2, 3);
    waitAck(3'b001, "mr_ack", n);
    applyStimulus(3'b000, 3'b000);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before summary");
    $fatal(1, "[TB] watchdog");
  end

endmodule
